// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/data hazard stall and branch fetch-hold controller
// for a 5-stage in-order core without forwarding or branch prediction.
// Control outputs are combinational from the registered FSM state and the
// current pipeline inputs; state, wait counter, perf counters and the
// timeout flag are registered.
module hazard_ctrl #(
  parameter int PC_W     = 8,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [6:0]       id_opcode_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic             br_resolved_i,
  input  logic             br_taken_i,
  input  logic [PC_W-1:0]  br_target_i,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic [PC_W-1:0]  pc_target_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] redirect_count_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_BR_WAIT = 2'b01;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  localparam int                WC_W      = $clog2(MAX_WAIT);
  localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] redir_q, redir_d;
  logic             tout_q, tout_d;
  logic             hazard_s;

  // Register-file sources read by each instruction class.
  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_B) || (op == OP_S) ||
           (op == OP_I) || (op == OP_LW);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_B) || (op == OP_S);
  endfunction

  // A source conflicts if an in-flight EX or MEM writer targets it; x0 never does.
  function automatic logic src_conflict(input logic [4:0] rs, input logic [4:0] exrd,
                                        input logic exw, input logic [4:0] memrd,
                                        input logic memw);
    return (rs != 5'd0) && ((exw && (rs == exrd)) || (memw && (rs == memrd)));
  endfunction

  // Data hazard detection for the instruction currently in ID.
  always_comb begin
    hazard_s = id_valid_i &&
               ((uses_rs1(id_opcode_i) &&
                 src_conflict(id_rs1_i, ex_rd_i, ex_regwrite_i, mem_rd_i, mem_regwrite_i)) ||
                (uses_rs2(id_opcode_i) &&
                 src_conflict(id_rs2_i, ex_rd_i, ex_regwrite_i, mem_rd_i, mem_regwrite_i)));
  end

  // Control outputs and next-state selection.
  always_comb begin
    state_d       = ST_RUN;
    wait_d        = '0;
    tout_d        = tout_q;
    pc_we_o       = 1'b0;
    pc_sel_o      = 1'b0;
    pc_target_o   = '0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hazard_s) begin
          idex_bubble_o = 1'b1;
          state_d       = ST_RUN;
        end else if (id_valid_i && ((id_opcode_i == OP_B) || (id_opcode_i == OP_J))) begin
          // Branch moves to EX; hold the PC and squash the wrong-path fetch.
          ifid_we_o    = 1'b1;
          ifid_flush_o = 1'b1;
          state_d      = ST_BR_WAIT;
        end else begin
          pc_we_o   = 1'b1;
          ifid_we_o = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_BR_WAIT: begin
        ifid_we_o    = 1'b1;
        ifid_flush_o = 1'b1;
        pc_target_o  = br_target_i;
        if (br_resolved_i) begin
          pc_we_o  = 1'b1;
          pc_sel_o = br_taken_i;
          state_d  = ST_RUN;
        end else if (wait_q == WAIT_LAST) begin
          // Resolution never arrived: fall through sequentially and flag it.
          pc_we_o = 1'b1;
          tout_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          wait_d  = wait_q + WC_W'(1);
          state_d = ST_BR_WAIT;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating performance counter updates.
  always_comb begin
    stall_d = stall_q;
    redir_d = redir_q;
    if ((idex_bubble_o || (state_q == ST_BR_WAIT)) && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
    if ((state_q == ST_BR_WAIT) && br_resolved_i && br_taken_i && (redir_q != CNT_MAX)) begin
      redir_d = redir_q + CNT_W'(1);
    end else begin
      redir_d = redir_q;
    end
  end

  // State, wait counter, perf counters and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      redir_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      redir_q <= redir_d;
      tout_q  <= tout_d;
    end
  end

  assign timeout_err_o    = tout_q;
  assign stall_count_o    = stall_q;
  assign redirect_count_o = redir_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes the modelled
// outputs to a queue; they are popped and compared at the falling edge.
module tb_hazard_ctrl;

  localparam int PC_W     = 8;
  localparam int CNT_W    = 5;
  localparam int MAX_WAIT = 4;

  logic             clk, rst_n;
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd;
  logic             ex_regwrite, mem_regwrite;
  logic             br_resolved, br_taken;
  logic [PC_W-1:0]  br_target;
  logic             pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, timeout_err;
  logic [PC_W-1:0]  pc_target;
  logic [CNT_W-1:0] stall_count, redirect_count;
  logic [1:0]       state;

  hazard_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_opcode_i(id_opcode),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
    .br_resolved_i(br_resolved), .br_taken_i(br_taken), .br_target_i(br_target),
    .pc_we_o(pc_we), .pc_sel_o(pc_sel), .pc_target_o(pc_target),
    .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble),
    .timeout_err_o(timeout_err), .stall_count_o(stall_count),
    .redirect_count_o(redirect_count), .state_o(state)
  );

  typedef struct packed {
    logic             pc_we;
    logic             pc_sel;
    logic [PC_W-1:0]  pc_target;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             tout;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] redir;
    logic [1:0]       st;
  } exp_t;

  exp_t sb_q[$];

  int checks_q   = 0;
  int failures_q = 0;

  // Reference model state.
  logic [1:0]       m_state;
  int               m_wait;
  logic [CNT_W-1:0] m_stall, m_redir;
  logic             m_tout;

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_q++;
    if (act !== exp) begin
      failures_q++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'b00;
    m_wait  = 0;
    m_stall = '0;
    m_redir = '0;
    m_tout  = 1'b0;
  endtask

  function automatic logic reads_rs1(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b1100011, 7'b0100011, 7'b0010011, 7'b0000011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b1100011, 7'b0100011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle, push the model's expectation, compare at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] erd, input logic ew,
                      input logic [4:0] mrd, input logic mw, input logic res,
                      input logic tk, input logic [PC_W-1:0] tgt);
    exp_t e, o;
    logic haz, h1, h2;
    logic [1:0] nst;
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2;
    ex_rd = erd; ex_regwrite = ew; mem_rd = mrd; mem_regwrite = mw;
    br_resolved = res; br_taken = tk; br_target = tgt;

    h1  = reads_rs1(op) && (rs1 != 5'd0) && ((ew && rs1 == erd) || (mw && rs1 == mrd));
    h2  = reads_rs2(op) && (rs2 != 5'd0) && ((ew && rs2 == erd) || (mw && rs2 == mrd));
    haz = v && (h1 || h2);
    e = '0;
    e.tout = m_tout; e.stall = m_stall; e.redir = m_redir; e.st = m_state;
    nst = 2'b00;
    if (m_state == 2'b01) begin
      e.ifid_we = 1'b1; e.ifid_flush = 1'b1; e.pc_target = tgt;
      if (res) begin
        e.pc_we = 1'b1; e.pc_sel = tk;
      end else if (m_wait == MAX_WAIT - 1) begin
        e.pc_we = 1'b1;
      end else begin
        nst = 2'b01;
      end
    end else if (haz) begin
      e.idex_bubble = 1'b1;
    end else if (v && (op == 7'b1100011 || op == 7'b1101111)) begin
      e.ifid_we = 1'b1; e.ifid_flush = 1'b1; nst = 2'b01;
    end else begin
      e.pc_we = 1'b1; e.ifid_we = 1'b1;
    end
    sb_q.push_back(e);

    @(negedge clk);
    o = sb_q.pop_front();
    check_val("pc_we",       32'(pc_we),          32'(o.pc_we));
    check_val("pc_sel",      32'(pc_sel),         32'(o.pc_sel));
    check_val("pc_target",   32'(pc_target),      32'(o.pc_target));
    check_val("ifid_we",     32'(ifid_we),        32'(o.ifid_we));
    check_val("ifid_flush",  32'(ifid_flush),     32'(o.ifid_flush));
    check_val("idex_bubble", 32'(idex_bubble),    32'(o.idex_bubble));
    check_val("timeout_err", 32'(timeout_err),    32'(o.tout));
    check_val("stall_count", 32'(stall_count),    32'(o.stall));
    check_val("redir_count", 32'(redirect_count), 32'(o.redir));
    check_val("state",       32'(state),          32'(o.st));

    @(posedge clk);
    if (rst_n) begin
      if ((e.idex_bubble || m_state == 2'b01) && m_stall != SAT) m_stall = m_stall + 1'b1;
      if (m_state == 2'b01 && res && tk && m_redir != SAT) m_redir = m_redir + 1'b1;
      if (m_state == 2'b01 && !res && m_wait == MAX_WAIT - 1) m_tout = 1'b1;
      m_wait  = (m_state == 2'b01 && nst == 2'b01) ? m_wait + 1 : 0;
      m_state = nst;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [6:0] ops [7];
    ops = '{7'b0110011, 7'b1100011, 7'b0100011, 7'b0010011,
            7'b0000011, 7'b1101111, 7'b0110111};
    rst_n = 1'b0;
    id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0;
    ex_rd = '0; ex_regwrite = 1'b0; mem_rd = '0; mem_regwrite = 1'b0;
    br_resolved = 1'b0; br_taken = 1'b0; br_target = '0;
    model_reset();
    #8;
    check_val("rst_pc_we",   32'(pc_we),          32'd1);
    check_val("rst_ifid_we", 32'(ifid_we),        32'd1);
    check_val("rst_stall",   32'(stall_count),    32'd0);
    check_val("rst_state",   32'(state),          32'd0);
    #4 rst_n = 1'b1;

    idle();
    // R-type rs2 hazard on EX, then on MEM, then cleared.
    step(1'b1, 7'b0110011, 5'd1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 7'b0110011, 5'd1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 7'b0110011, 5'd1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    check_val("stall_after_rtype", 32'(stall_count), 32'd2);
    // Unused rs2 and x0 never hazard; br_resolved in RUN is ignored.
    step(1'b1, 7'b0010011, 5'd3, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'h55);
    step(1'b1, 7'b0010011, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, '0);
    // B-type, taken redirect to 0x40.
    step(1'b1, 7'b1100011, 5'd2, 5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 8'h40);
    idle();
    // B-type with rs1 hazard first, then not-taken.
    step(1'b1, 7'b1100011, 5'd9, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 7'b1100011, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h20);
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h80);
    // J-type with no resolution: timeout on the 4th wait cycle, then sticky.
    step(1'b1, 7'b1101111, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < MAX_WAIT; i++)
      step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h33);
    idle();
    check_val("timeout_sticky", 32'(timeout_err), 32'd1);
    // Long stall drives stall_count into saturation.
    for (int i = 0; i < 40; i++)
      step(1'b1, 7'b0000011, 5'd4, 5'd0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    check_val("stall_saturated", 32'(stall_count), 32'(SAT));
    // Random mix: frequent hazards, branches, resolves and timeouts.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), ops[$urandom_range(0, 6)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    // Reset asserted mid-BR_WAIT takes effect without a clock edge.
    idle();
    step(1'b1, 7'b1100011, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    check_val("in_br_wait", 32'(state), 32'd1);
    id_valid = 1'b0; br_resolved = 1'b1; br_taken = 1'b1; br_target = 8'h77;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("async_rst_state",  32'(state),          32'd0);
    check_val("async_rst_pc_sel", 32'(pc_sel),         32'd0);
    check_val("async_rst_pc_we",  32'(pc_we),          32'd1);
    check_val("async_rst_tout",   32'(timeout_err),    32'd0);
    check_val("async_rst_redir",  32'(redirect_count), 32'd0);
    #1 rst_n = 1'b1;
    idle();
    step(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and fetch-sequencing controller for the 5-stage RISC-V core (no forwarding unit, no branch prediction). It sits beside the IF/ID register and decides each cycle whether the PC and IF/ID register advance, whether a bubble enters ID/EX, and whether fetched instructions are flushed. It also holds fetch while a branch or jump resolves in EX, then redirects the PC. It keeps saturating stall and redirect counters for performance debug.

## Interface
- PC_W, 8, PC / branch-target width
- CNT_W, 16, width of performance counters
- MAX_WAIT, 4, max cycles in BR_WAIT before timeout (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction (0 = NOP)
- id_opcode  in  7  opcode of instruction in ID
- id_rs1, id_rs2  in  5 each  source registers in ID
- ex_rd  in  5  destination of instruction in EX
- ex_regwrite  in  1  EX instruction writes the register file
- mem_rd  in  5  destination of instruction in MEM
- mem_regwrite  in  1  MEM instruction writes the register file
- br_resolved  in  1  B/J instruction in EX has a resolved outcome this cycle
- br_taken  in  1  resolved outcome is taken (J always 1)
- br_target  in  PC_W  resolved target address
- pc_we  out  1  PC register loads next value
- pc_sel  out  1  1 = load pc_target, 0 = PC+4
- pc_target  out  PC_W  redirect address
- ifid_we  out  1  IF/ID register loads
- ifid_flush  out  1  IF/ID loads NOP (0x00000000) instead of fetched word
- idex_bubble  out  1  ID/EX loads NOP instead of ID contents
- timeout_err  out  1  sticky: BR_WAIT expired without br_resolved
- stall_count  out  CNT_W  saturating count of stall/wait cycles
- redirect_count  out  CNT_W  saturating count of taken redirects
- state  out  2  current FSM state (debug)

## Operation
- Source usage by opcode: R (0110011), B (1100011), S (0100011) use rs1 and rs2; I (0010011), Lw (0000011) use rs1 only; J (1101111) and all others use none.
- Hazard: id_valid && a used source equals ex_rd with ex_regwrite, or equals mem_rd with mem_regwrite; a source of x0 never hazards. WB writes before ID reads, so WB is not checked.
- States: RUN=2'b00, BR_WAIT=2'b01. 2'b10/2'b11 are illegal and return to RUN.
- RUN, hazard: pc_we=0, ifid_we=0, idex_bubble=1; stay in RUN. Repeats until the hazard clears.
- RUN, no hazard, id_opcode B or J with id_valid: the instruction advances to EX; pc_we=0, ifid_we=1, ifid_flush=1; next state BR_WAIT. Hazard takes priority over this.
- RUN, otherwise: pc_we=1, pc_sel=0, ifid_we=1, all else 0.
- BR_WAIT: pc_we=0, ifid_we=1, ifid_flush=1, idex_bubble=0.
  - On br_resolved: pc_we=1, pc_sel=br_taken, pc_target=br_target; next RUN.
  - If wait_cnt reaches MAX_WAIT-1 without br_resolved: pc_we=1, pc_sel=0, set timeout_err; next RUN.
- wait_cnt clears on entry to BR_WAIT and increments each cycle in BR_WAIT.
- br_resolved in RUN is ignored.
- pc_target = br_target in BR_WAIT, otherwise 0.
- stall_count increments in every cycle where idex_bubble=1 or state=BR_WAIT. It saturates at all-ones.
- redirect_count increments on br_resolved && br_taken in BR_WAIT. It saturates at all-ones.

## Timing
- Control outputs are combinational from the registered state and the current inputs. state, wait_cnt, counters and timeout_err are registered on the rising clk edge.
- Reset (async, rst_n=0): state=RUN, wait_cnt=0, stall_count=0, redirect_count=0, timeout_err=0. With id_valid=0 this gives pc_we=1, ifid_we=1, and pc_sel/ifid_flush/idex_bubble/pc_target all 0.
- Reset during BR_WAIT abandons the wait immediately; no redirect is issued.
- Data-stall latency is 0: stall outputs are asserted in the same cycle the hazard is visible.
- Branch penalty: 1 cycle for RUN→BR_WAIT plus cycles until br_resolved. With resolution one cycle after the branch enters EX, the redirect PC loads at the end of the 2nd cycle after the branch leaves ID.

## Test plan
- Reset with id_valid=0 → pc_we=1, ifid_we=1, counters 0, state=00. Assert rst_n low mid-BR_WAIT → state=00 asynchronously, no pc_we pulse with pc_sel=1.
- id_opcode=0110011, rs2=5, ex_rd=5, ex_regwrite=1 → idex_bubble=1, pc_we=0, ifid_we=0. Next cycle the hazard moves to mem_rd=5 → still stalled. Then cleared → pc_we=1; stall_count=2.
- id_opcode=0010011, rs2=7 (unused), ex_rd=7 → no stall. rs1=0, ex_rd=0, ex_regwrite=1 → no stall.
- B-type, no hazard → cycle 0: ifid_flush=1, pc_we=0, state→01. Cycle 1: br_resolved=1, br_taken=1, br_target=0x40 → pc_we=1, pc_sel=1, pc_target=0x40, state→00, redirect_count=1.
- B-type with rs1=ex_rd hazard → stall first (state stays 00). After the hazard clears, enter BR_WAIT. Resolve not-taken → pc_sel=0, redirect_count unchanged.
- BR_WAIT with br_resolved held 0 and MAX_WAIT=4 → on the 4th wait cycle pc_we=1, pc_sel=0, timeout_err=1, and it stays 1 until reset. Drive stall_count near all-ones → it saturates with no wrap.
